// File: rtl/apb_regw_ctrl.sv
// apb_regw_ctrl: APB slave front-end that decodes transfers into one-hot register bank strobes
module apb_regw_ctrl #(
    parameter int DWIDTH      = 8,
    parameter int REGWN       = 5,
    parameter int AWIDTH      = 4,
    parameter int WAIT_STATES = 1
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [AWIDTH-1:0]       PADDR,
    input  logic [DWIDTH-1:0]       PWDATA,
    input  logic [REGWN*DWIDTH-1:0] regs_rdata,
    output logic [DWIDTH-1:0]       PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR,
    output logic [REGWN-1:0]        pselw_r,
    output logic [REGWN-1:0]        pselw_w,
    output logic [DWIDTH-1:0]       wdata_out
);
    typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;
    state_t state;
    logic [AWIDTH-1:0] addr_q, addr_n;
    logic [DWIDTH-1:0] data_q, data_n, rdata_n;
    logic [REGWN-1:0]  sel_n;
    logic [3:0]        cnt;
    logic              write_q, write_n, setup, hold, go_access, valid;
    // Next-transfer view: a setup edge takes the live bus, otherwise the latched copy is used
    always_comb begin
        setup     = PSEL && !PENABLE && state != WAIT;
        hold      = state == WAIT && PSEL && PENABLE;
        addr_n    = setup ? PADDR : addr_q;
        write_n   = setup ? PWRITE : write_q;
        data_n    = setup ? PWDATA : data_q;
        go_access = setup ? WAIT_STATES == 0 : hold && cnt == 4'd0;
        valid     = int'(addr_n) < REGWN;
        sel_n     = '0;
        rdata_n   = '0;
        for (int i = 0; i < REGWN; i++) begin
            if (int'(addr_n) == i) begin
                sel_n[i] = 1'b1;
                rdata_n  = regs_rdata[i*DWIDTH +: DWIDTH];
            end
        end
    end
    // FSM with outputs registered on entry to ACCESS so they are high for exactly that cycle
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            data_q    <= '0;
            PREADY    <= 1'b0;
            PSLVERR   <= 1'b0;
            PRDATA    <= '0;
            pselw_r   <= '0;
            pselw_w   <= '0;
            wdata_out <= '0;
        end else begin
            addr_q    <= addr_n;
            write_q   <= write_n;
            data_q    <= data_n;
            PREADY    <= go_access;
            PSLVERR   <= go_access && !valid;
            PRDATA    <= go_access && !write_n ? rdata_n : '0;
            pselw_r   <= go_access && !write_n ? sel_n : '0;
            pselw_w   <= go_access && write_n ? sel_n : '0;
            wdata_out <= go_access && write_n && valid ? data_n : '0;
            if (go_access) begin
                state <= ACCESS;
                cnt   <= '0;
            end else if (setup) begin
                state <= WAIT;
                cnt   <= 4'(WAIT_STATES - 1);
            end else if (hold) begin
                cnt   <= cnt - 4'd1;
            end else begin
                state <= IDLE;
                cnt   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_apb_regw_ctrl.sv
// tb_apb_regw_ctrl: directed APB transfers against three wait-state configurations
module tb_apb_regw_ctrl;
    logic        PCLK = 1'b0;
    logic        PRESET, PSEL, PENABLE, PWRITE;
    logic [3:0]  PADDR;
    logic [7:0]  PWDATA;
    logic [39:0] regs_rdata = {8'h3C, 8'h44, 8'h33, 8'h22, 8'h11};
    logic [7:0]  rd1, rd0, rd3, wd1, wd0, wd3;
    logic        rdy1, rdy0, rdy3, err1, err0, err3;
    logic [4:0]  r1, r0, r3, w1, w0, w3;
    int          n_cmp = 0, n_err = 0, cyc = 0, sel = 1;
    int          sw1 = 0, sr1 = 0, both1 = 0, st3 = 0;
    logic        o_ready, o_err;
    logic [4:0]  o_r, o_w;
    logic [7:0]  o_rd, o_wd;
    logic        a_ready, a_err;
    logic [4:0]  a_r, a_w;
    logic [7:0]  a_rd, a_wd;
    int          a_cyc, nw, c1, k;

    always #5 PCLK = ~PCLK;

    apb_regw_ctrl #(.WAIT_STATES(1)) u1 (.PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .regs_rdata(regs_rdata), .PRDATA(rd1),
        .PREADY(rdy1), .PSLVERR(err1), .pselw_r(r1), .pselw_w(w1), .wdata_out(wd1));
    apb_regw_ctrl #(.WAIT_STATES(0)) u0 (.PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .regs_rdata(regs_rdata), .PRDATA(rd0),
        .PREADY(rdy0), .PSLVERR(err0), .pselw_r(r0), .pselw_w(w0), .wdata_out(wd0));
    apb_regw_ctrl #(.WAIT_STATES(3)) u3 (.PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .regs_rdata(regs_rdata), .PRDATA(rd3),
        .PREADY(rdy3), .PSLVERR(err3), .pselw_r(r3), .pselw_w(w3), .wdata_out(wd3));

    always_comb begin
        o_ready = sel == 0 ? rdy0 : sel == 3 ? rdy3 : rdy1;
        o_err   = sel == 0 ? err0 : sel == 3 ? err3 : err1;
        o_r     = sel == 0 ? r0 : sel == 3 ? r3 : r1;
        o_w     = sel == 0 ? w0 : sel == 3 ? w3 : w1;
        o_rd    = sel == 0 ? rd0 : sel == 3 ? rd3 : rd1;
        o_wd    = sel == 0 ? wd0 : sel == 3 ? wd3 : wd1;
    end

    always @(posedge PCLK) cyc <= cyc + 1;

    always @(negedge PCLK) begin
        if (|w1) sw1 <= sw1 + 1;
        if (|r1) sr1 <= sr1 + 1;
        if (|w1 && |r1) both1 <= both1 + 1;
        if (|w3 || |r3) st3 <= st3 + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Full APB transfer: setup, access phase held until PREADY, bus scrambled after setup
    task automatic xfer(input int d, input logic w, input logic [3:0] a, input logic [7:0] dat);
        logic quiet;
        sel = d;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = dat;
        tick();
        PENABLE = 1'b1; PWRITE = ~w; PADDR = ~a; PWDATA = ~dat;
        nw = 0;
        quiet = 1'b1;
        while (!o_ready && nw < 20) begin
            if (o_err || |o_r || |o_w || |o_rd) quiet = 1'b0;
            tick();
            nw++;
        end
        check("wait_quiet", 32'(quiet), 32'd1);
        a_ready = o_ready; a_err = o_err; a_r = o_r; a_w = o_w; a_rd = o_rd; a_wd = o_wd; a_cyc = cyc;
        tick();
    endtask

    task automatic idle();
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
        tick(); tick();
        check("rst_ready", 32'(rdy1), 0);
        check("rst_err", 32'(err1), 0);
        check("rst_rdata", 32'(rd1), 0);
        check("rst_sel_r", 32'(r1), 0);
        check("rst_sel_w", 32'(w1), 0);
        check("rst_wdata", 32'(wd1), 0);
        PRESET = 1'b0;
        tick();

        c1 = sw1;
        xfer(1, 1'b1, 4'd2, 8'hA5);
        check("w2_waits", 32'(nw), 1);
        check("w2_ready", 32'(a_ready), 1);
        check("w2_sel_w", 32'(a_w), 32'b00100);
        check("w2_sel_r", 32'(a_r), 0);
        check("w2_wdata", 32'(a_wd), 32'hA5);
        check("w2_err", 32'(a_err), 0);
        idle();
        check("w2_done_ready", 32'(rdy1), 0);
        check("w2_done_sel_w", 32'(w1), 0);
        tick();
        check("w2_strobe_cycles", 32'(sw1 - c1), 1);

        xfer(1, 1'b0, 4'd4, 8'h00);
        check("r4_rdata", 32'(a_rd), 32'h3C);
        check("r4_sel_r", 32'(a_r), 32'b10000);
        check("r4_ready", 32'(a_ready), 1);
        check("r4_err", 32'(a_err), 0);
        idle();
        check("r4_done_rdata", 32'(rd1), 0);
        tick();

        c1 = sw1;
        xfer(1, 1'b1, 4'd7, 8'h5A);
        check("w7_err", 32'(a_err), 1);
        check("w7_ready", 32'(a_ready), 1);
        check("w7_sel_w", 32'(a_w), 0);
        idle();
        check("w7_done_err", 32'(err1), 0);
        tick();
        check("w7_no_strobe", 32'(sw1 - c1), 0);

        xfer(1, 1'b0, 4'd5, 8'h00);
        check("r5_err", 32'(a_err), 1);
        check("r5_rdata", 32'(a_rd), 0);
        check("r5_sel_r", 32'(a_r), 0);
        idle();
        tick();

        xfer(1, 1'b1, 4'd0, 8'h77);
        check("b2b_sel_w", 32'(a_w), 32'b00001);
        k = a_cyc;
        xfer(1, 1'b0, 4'd1, 8'h00);
        check("b2b_sel_r", 32'(a_r), 32'b00010);
        check("b2b_rdata", 32'(a_rd), 32'h22);
        check("b2b_spacing", 32'(a_cyc - k), 3);
        idle();
        tick();

        c1 = sw1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 4'd3; PWDATA = 8'h5A;
        tick();
        PENABLE = 1'b1; PRESET = 1'b1;
        tick();
        check("rst_mid_ready", 32'(rdy1), 0);
        check("rst_mid_sel_w", 32'(w1), 0);
        check("rst_mid_wdata", 32'(wd1), 0);
        PRESET = 1'b0;
        idle();
        tick(); tick();
        check("rst_mid_no_strobe", 32'(sw1 - c1), 0);
        xfer(1, 1'b1, 4'd3, 8'h5A);
        check("w3_sel_w", 32'(a_w), 32'b01000);
        check("w3_wdata", 32'(a_wd), 32'h5A);
        idle();
        tick();

        xfer(0, 1'b0, 4'd0, 8'h00);
        check("ws0_waits", 32'(nw), 0);
        check("ws0_ready", 32'(a_ready), 1);
        check("ws0_rdata", 32'(a_rd), 32'h11);
        check("ws0_sel_r", 32'(a_r), 32'b00001);
        idle();
        tick(); tick(); tick(); tick();

        sel = 3;
        c1 = st3;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 4'd1; PWDATA = 8'hC3;
        tick();
        PENABLE = 1'b1;
        tick();
        idle();
        tick();
        check("abort_ready", 32'(rdy3), 0);
        for (int i = 0; i < 5; i++) tick();
        check("abort_no_strobe", 32'(st3 - c1), 0);
        check("abort_idle_ready", 32'(rdy3), 0);

        xfer(3, 1'b1, 4'd1, 8'hC3);
        check("ws3_waits", 32'(nw), 3);
        check("ws3_sel_w", 32'(a_w), 32'b00010);
        check("ws3_wdata", 32'(a_wd), 32'hC3);
        idle();
        tick(); tick();
        check("never_both", 32'(both1), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/apb_regw_ctrl.md
APB_REGW_CTRL -- requirements
Module: apb_regw_ctrl

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 8, giving the data width of PWDATA, PRDATA and each register.
REQ-002 The block SHALL have parameter REGWN, default 5, giving the number of registers, addressed 0..REGWN-1.
REQ-003 The block SHALL have parameter AWIDTH, default 4, giving the PADDR width (register index, no byte offset).
REQ-004 The block SHALL have parameter WAIT_STATES, default 1, range 0..15, giving the PREADY-low cycles inserted per transfer.
REQ-005 The block SHALL have port PCLK  in  1  the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port PRESET  in  1  reset, synchronous and active-high.
REQ-007 The block SHALL have port PSEL  in  1  APB slave select.
REQ-008 The block SHALL have port PENABLE  in  1  APB access phase.
REQ-009 The block SHALL have port PWRITE  in  1  1=write, 0=read.
REQ-010 The block SHALL have port PADDR  in  AWIDTH  register index.
REQ-011 The block SHALL have port PWDATA  in  DWIDTH  write data.
REQ-012 The block SHALL have port regs_rdata  in  REGWN*DWIDTH  flattened register values, register i in bits [i*DWIDTH +: DWIDTH].
REQ-013 The block SHALL have port PRDATA  out  DWIDTH  read data.
REQ-014 The block SHALL have port PREADY  out  1  transfer-complete indication.
REQ-015 The block SHALL have port PSLVERR  out  1  error response.
REQ-016 The block SHALL have port pselw_r  out  REGWN  one-hot read strobe to the register bank.
REQ-017 The block SHALL have port pselw_w  out  REGWN  one-hot write strobe to the register bank.
REQ-018 The block SHALL have port wdata_out  out  DWIDTH  latched write data to the register bank.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, WAIT and ACCESS.
REQ-020 From IDLE or ACCESS, a PCLK edge with PSEL=1 and PENABLE=0 SHALL latch PADDR, PWRITE and PWDATA, then enter WAIT with the wait counter set to WAIT_STATES-1, or enter ACCESS directly when WAIT_STATES=0.
REQ-021 In WAIT, PREADY SHALL be 0; the counter SHALL decrement each edge, and the edge at which the counter is 0 SHALL move the FSM to ACCESS.
REQ-022 In ACCESS, PREADY SHALL be 1; the next edge completes the transfer and SHALL return to IDLE unless REQ-020 applies (back-to-back transfer, no IDLE cycle).
REQ-023 A latched address is valid iff latched PADDR < REGWN; the comparison SHALL be done at full AWIDTH width, with no truncation.
REQ-024 During ACCESS with a valid read, pselw_r SHALL be high only at bit PADDR, and PRDATA SHALL equal the regs_rdata slice at PADDR.
REQ-025 During ACCESS with a valid write, pselw_w SHALL be high only at bit PADDR, and wdata_out SHALL hold the latched PWDATA.
REQ-026 The strobes SHALL be high for exactly one cycle per transfer, and pselw_r and pselw_w SHALL never both be nonzero.
REQ-027 During ACCESS with an invalid address, PSLVERR SHALL be 1, both strobes SHALL be 0 and PRDATA SHALL be 0.
REQ-028 Outside ACCESS, PREADY, PSLVERR, PRDATA, pselw_r and pselw_w SHALL all be 0.
REQ-029 In WAIT or ACCESS, an edge sampling PSEL=0, or PSEL=1 with PENABLE=0 while in WAIT, SHALL abort to IDLE (then REQ-020 applies if PENABLE=0); an aborted transfer SHALL issue no strobe.
REQ-030 Changes on PADDR, PWRITE or PWDATA after the setup edge SHALL have no effect on the transfer in progress.
REQ-031 With WAIT_STATES=W, a transfer SHALL take W+2 cycles from the setup cycle to the completing edge.

Reset
REQ-032 PRESET=1 at a PCLK edge SHALL force IDLE, clear the wait counter, the latched address, control and data, and set every output to 0 at that edge.
REQ-033 PRESET SHALL take priority over every other input, including mid-transfer, and a transfer interrupted by reset SHALL produce no strobe.
REQ-034 After PRESET is released, the first setup edge SHALL start a normal transfer.

Verification (DWIDTH=8, REGWN=5, WAIT_STATES=1 unless noted)
REQ-035 Write PADDR=2, PWDATA=8'hA5 -> PREADY is low for 1 cycle then high for 1 cycle; pselw_w=5'b00100 and wdata_out=8'hA5 for exactly one cycle; PSLVERR=0.
REQ-036 Read PADDR=4 with regs_rdata slice 4=8'h3C -> in ACCESS, PRDATA=8'h3C, pselw_r=5'b10000 and PREADY=1; elsewhere PRDATA=0.
REQ-037 Write to PADDR=7 -> PSLVERR=1 and PREADY=1 in ACCESS; pselw_w stays 5'b00000 throughout.
REQ-038 Back-to-back write to addr 0 then read of addr 1 with no IDLE cycle -> strobes 5'b00001 (w) then 5'b00010 (r), 3 cycles apart.
REQ-039 PRESET asserted in the WAIT cycle of a write to addr 3 -> no strobe, all outputs 0; the next write to addr 3 completes normally.
REQ-040 WAIT_STATES=0, read addr 0 -> PREADY=1 in the cycle after setup; PSEL dropped in WAIT with WAIT_STATES=3 -> abort to IDLE, no strobe.
